fft_frame_ctrl: RTL and testbench
=================================

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter FFT_LEN, default 512, meaning points per frame (power of two, 8..4096).
REQ-002 SHALL have parameter CNT_W, default 9, meaning log2(FFT_LEN).
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle pulse launching a job; ignored unless idle.
REQ-006 num_frames  in  8  frames in the job, sampled at start; 0 treated as 1.
REQ-007 inverse_cfg  in  1  transform direction, sampled at start.
REQ-008 in_valid / in_ready  in / out  1 / 1  upstream sample handshake.
REQ-009 in_real, in_imag  in  32 each  upstream sample.
REQ-010 fft_sink_valid, fft_sink_sop, fft_sink_eop  out  1 each  FFT core sink controls.
REQ-011 fft_sink_ready  in  1  FFT core sink ready.
REQ-012 fft_sink_error  out  2  tied 2'b00.
REQ-013 fft_sink_real, fft_sink_imag  out  32 each  sample to core.
REQ-014 fft_inverse  out  1  direction to core.
REQ-015 fft_source_valid, fft_source_sop, fft_source_eop  in  1 each  FFT core source controls.
REQ-016 fft_source_error  in  2  core error; fft_source_real, fft_source_imag  in  32 each; fft_source_exp  in  6.
REQ-017 fft_source_ready  out  1  ready to core.
REQ-018 out_valid, out_sop, out_eop  out  1 each; out_ready  in  1  downstream handshake.
REQ-019 out_real, out_imag  out  32 each; out_exp  out  6  block exponent.
REQ-020 busy  out  1; done  out  1 (one-cycle pulse); err  out  2 (sticky: bit0 core error, bit1 framing error).

Function
REQ-021 FSM states SHALL be IDLE, FEED, DRAIN; IDLE->FEED on start; FEED->DRAIN when the last sample of the last frame transfers to the core; DRAIN->IDLE when the last output eop transfers downstream.
REQ-022 In FEED the sink path SHALL be combinational pass-through: fft_sink_valid=in_valid, in_ready=fft_sink_ready, data unmodified; in IDLE and DRAIN, in_ready=0 and fft_sink_valid=0.
REQ-023 A transfer SHALL occur when valid and ready are both high in the same cycle; counters advance only on transfers.
REQ-024 In-sample counter (CNT_W bits) SHALL reset to 0 at start, increment per sink transfer, wrap from FFT_LEN-1 to 0 and increment the fed-frame counter on wrap.
REQ-025 fft_sink_sop SHALL be high when counter=0 and fft_sink_eop when counter=FFT_LEN-1, both qualified by fft_sink_valid.
REQ-026 fft_inverse SHALL hold the latched inverse_cfg from start until the next start; it SHALL not change mid-job.
REQ-027 Source path SHALL be pass-through: out_valid=fft_source_valid, fft_source_ready=out_ready, data/exp/sop/eop forwarded unmodified, in all states.
REQ-028 Out-sample counter SHALL reset to 0 at start, increment per output transfer, wrap at FFT_LEN-1 and increment the received-frame counter on wrap.
REQ-029 A source transfer with sop≠(count=0) or eop≠(count=FFT_LEN-1) SHALL set err[1]; fft_source_error≠0 on a transfer SHALL set err[0]; the job SHALL continue.
REQ-030 done SHALL pulse one cycle on the DRAIN->IDLE transition; busy SHALL be high in FEED and DRAIN.
REQ-031 A single transfer that both completes the last input frame and the last output frame SHALL go FEED->IDLE directly with done pulse.
REQ-032 start while busy SHALL be ignored with no effect on counters, err, or fft_inverse.
REQ-033 err SHALL clear only at an accepted start or reset.

Reset
REQ-034 On reset_n low, asynchronously: state=IDLE, all counters=0, busy=0, done=0, err=0, fft_inverse=0; derived outputs in_ready=0, fft_sink_valid=0.
REQ-035 Reset mid-job SHALL abandon the job; no done pulse; pass-through source path stays live.

Verification
REQ-036 FFT_LEN=8, start num_frames=2 inverse_cfg=1, continuous valid/ready -> sop at samples 0,8, eop at 7,15, fft_inverse=1, state FEED->DRAIN after 16th transfer.
REQ-037 Core returns 16 output samples with correct sop/eop, out_ready toggling 50% -> all 16 forwarded in order, done pulses once, err=00.
REQ-038 fft_sink_ready low for 5 cycles mid-frame -> in_ready low, counter frozen, sop/eop positions unchanged.
REQ-039 Source eop at out-sample 5 of 8 -> err=2'b10 sticky until next start; fft_source_error=01 -> err[0] set.
REQ-040 start pulsed during FEED with inverse_cfg flipped -> ignored, fft_inverse unchanged; num_frames=0 -> exactly one frame.
REQ-041 reset_n asserted after 3 input samples -> immediate IDLE, busy=0, no done; new start begins with sop at sample 0.

Source files
------------

// File: rtl/fft_frame_ctrl_if.sv
// rtl/fft_frame_ctrl_if.sv - signal bundle between the FFT frame controller and its environment
//
// Purpose: groups the job control, upstream sample stream, FFT core sink/source
//          and downstream sample stream of fft_frame_ctrl.
// Modports:
//   slave  - the controller's view (fft_frame_ctrl)
//   master - the environment's view (upstream source, FFT core, downstream sink)
// Signals:
//   job       : start, num_frames[7:0], inverse_cfg, busy, done, err[1:0]
//   upstream  : in_valid, in_ready, in_real[31:0], in_imag[31:0]
//   core sink : fft_sink_valid/ready/sop/eop, fft_sink_error[1:0], fft_sink_real/imag[31:0], fft_inverse
//   core src  : fft_source_valid/ready/sop/eop, fft_source_error[1:0], fft_source_real/imag[31:0], fft_source_exp[5:0]
//   downstream: out_valid, out_ready, out_sop, out_eop, out_real/imag[31:0], out_exp[5:0]
interface fft_frame_ctrl_if;
  logic        start;
  logic [7:0]  num_frames;
  logic        inverse_cfg;
  logic        busy;
  logic        done;
  logic [1:0]  err;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_real;
  logic [31:0] in_imag;

  logic        fft_sink_valid;
  logic        fft_sink_ready;
  logic        fft_sink_sop;
  logic        fft_sink_eop;
  logic [1:0]  fft_sink_error;
  logic [31:0] fft_sink_real;
  logic [31:0] fft_sink_imag;
  logic        fft_inverse;

  logic        fft_source_valid;
  logic        fft_source_ready;
  logic        fft_source_sop;
  logic        fft_source_eop;
  logic [1:0]  fft_source_error;
  logic [31:0] fft_source_real;
  logic [31:0] fft_source_imag;
  logic [5:0]  fft_source_exp;

  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic [31:0] out_real;
  logic [31:0] out_imag;
  logic [5:0]  out_exp;

  modport slave (
    input  start, num_frames, inverse_cfg,
    output busy, done, err,
    input  in_valid, in_real, in_imag,
    output in_ready,
    output fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_error,
    output fft_sink_real, fft_sink_imag, fft_inverse,
    input  fft_sink_ready,
    input  fft_source_valid, fft_source_sop, fft_source_eop, fft_source_error,
    input  fft_source_real, fft_source_imag, fft_source_exp,
    output fft_source_ready,
    output out_valid, out_sop, out_eop, out_real, out_imag, out_exp,
    input  out_ready
  );

  modport master (
    output start, num_frames, inverse_cfg,
    input  busy, done, err,
    output in_valid, in_real, in_imag,
    input  in_ready,
    input  fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_error,
    input  fft_sink_real, fft_sink_imag, fft_inverse,
    output fft_sink_ready,
    output fft_source_valid, fft_source_sop, fft_source_eop, fft_source_error,
    output fft_source_real, fft_source_imag, fft_source_exp,
    input  fft_source_ready,
    input  out_valid, out_sop, out_eop, out_real, out_imag, out_exp,
    output out_ready
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - frames a multi-frame job into a streaming FFT core and checks its output framing
//
// Purpose: feeds num_frames frames of FFT_LEN samples from the upstream stream
//          into the FFT core (generating sop/eop), forwards the core output
//          downstream, and flags core errors and output framing errors.
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - fft_frame_ctrl_if.slave (job control, upstream, core sink/source, downstream)
module fft_frame_ctrl #(
  parameter int FFT_LEN = 512,
  parameter int CNT_W   = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  fft_frame_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FFT_LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [7:0]       in_frm_q, in_frm_d;
  logic [7:0]       out_frm_q, out_frm_d;
  logic [7:0]       frames_q, frames_d;
  logic             inv_q, inv_d;
  logic [1:0]       err_q, err_d;
  logic             done_q, done_d;

  logic feeding;
  logic busy;
  logic sink_xfer;
  logic src_xfer;
  logic last_in;
  logic last_out;

  assign feeding   = (state_q == FEED);
  assign busy      = (state_q != IDLE);
  assign sink_xfer = feeding && bus.in_valid && bus.fft_sink_ready;
  // Output accounting only runs during a job; the data path itself is always live.
  assign src_xfer  = busy && bus.fft_source_valid && bus.out_ready;
  assign last_in   = sink_xfer && (in_cnt_q == LAST) && (in_frm_q == frames_q - 8'd1);
  assign last_out  = src_xfer && (out_cnt_q == LAST) && (out_frm_q == frames_q - 8'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      in_frm_q  <= '0;
      out_frm_q <= '0;
      frames_q  <= '0;
      inv_q     <= 1'b0;
      err_q     <= 2'b00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      in_frm_q  <= in_frm_d;
      out_frm_q <= out_frm_d;
      frames_q  <= frames_d;
      inv_q     <= inv_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    in_frm_d  = in_frm_q;
    out_frm_d = out_frm_q;
    frames_d  = frames_q;
    inv_d     = inv_q;
    err_d     = err_q;
    done_d    = 1'b0;

    if (sink_xfer) begin
      if (in_cnt_q == LAST) begin
        in_cnt_d = '0;
        in_frm_d = in_frm_q + 8'd1;
      end else begin
        in_cnt_d = in_cnt_q + 1'b1;
      end
    end

    if (src_xfer) begin
      if (out_cnt_q == LAST) begin
        out_cnt_d = '0;
        out_frm_d = out_frm_q + 8'd1;
      end else begin
        out_cnt_d = out_cnt_q + 1'b1;
      end
      // Framing is judged against our own count, so a misplaced marker from
      // the core does not resynchronise the counter.
      if ((bus.fft_source_sop != (out_cnt_q == '0)) ||
          (bus.fft_source_eop != (out_cnt_q == LAST)))
        err_d[1] = 1'b1;
      if (bus.fft_source_error != 2'b00)
        err_d[0] = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = FEED;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          in_frm_d  = '0;
          out_frm_d = '0;
          frames_d  = (bus.num_frames == 8'd0) ? 8'd1 : bus.num_frames;
          inv_d     = bus.inverse_cfg;
          err_d     = 2'b00;
        end
      end
      FEED: begin
        // Last input and last output on the same edge skip DRAIN entirely.
        if (last_in && last_out) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (last_in) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_out) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready       = feeding && bus.fft_sink_ready;
  assign bus.fft_sink_valid = feeding && bus.in_valid;
  assign bus.fft_sink_sop   = bus.fft_sink_valid && (in_cnt_q == '0);
  assign bus.fft_sink_eop   = bus.fft_sink_valid && (in_cnt_q == LAST);
  assign bus.fft_sink_error = 2'b00;
  assign bus.fft_sink_real  = bus.in_real;
  assign bus.fft_sink_imag  = bus.in_imag;
  assign bus.fft_inverse    = inv_q;

  assign bus.out_valid        = bus.fft_source_valid;
  assign bus.fft_source_ready = bus.out_ready;
  assign bus.out_sop          = bus.fft_source_sop;
  assign bus.out_eop          = bus.fft_source_eop;
  assign bus.out_real         = bus.fft_source_real;
  assign bus.out_imag         = bus.fft_source_imag;
  assign bus.out_exp          = bus.fft_source_exp;

  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - scoreboard bench for fft_frame_ctrl with FFT_LEN=8
module tb_fft_frame_ctrl;
  localparam int LEN = 8;

  logic clk;
  logic reset_n;
  fft_frame_ctrl_if bus();

  fft_frame_ctrl #(.FFT_LEN(LEN), .CNT_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
    logic        sop;
    logic        eop;
    logic        inv;
  } sink_t;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
    logic        sop;
    logic        eop;
    logic [5:0]  ex;
  } out_t;

  sink_t sink_q[$];
  out_t  out_q[$];

  int n_pass = 0;
  int n_checks = 0;
  int done_cnt = 0;
  int done_base = 0;
  int frames = 1;
  logic exp_inv = 1'b0;
  logic [1:0] exp_err = 2'b00;
  int rdy_mode = 0;   // 0 random, 1 always high, 2 always low
  int out_mode = 0;   // 0 toggle every cycle, 1 always high
  bit gaps_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  always @(posedge clk) begin
    #2;
    if (rdy_mode == 0) bus.fft_sink_ready = ($urandom_range(0, 3) != 0);
    else bus.fft_sink_ready = (rdy_mode == 1);
  end

  always @(posedge clk) begin
    #2;
    if (out_mode == 1) bus.out_ready = 1'b1;
    else bus.out_ready = ~bus.out_ready;
  end

  sink_t se;
  out_t  oe;
  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.fft_sink_valid && bus.fft_sink_ready) begin
      if (sink_q.size() == 0) fail_now("sink_unexpected_transfer");
      else begin
        se = sink_q.pop_front();
        chk("sink_data", {bus.fft_sink_real, bus.fft_sink_imag}, {se.re, se.im});
        chk("sink_ctrl", {bus.fft_sink_sop, bus.fft_sink_eop, bus.fft_inverse}, {se.sop, se.eop, se.inv});
        chk("sink_in_ready", bus.in_ready, 1);
      end
    end
    if (bus.out_valid && bus.out_ready) begin
      if (out_q.size() == 0) fail_now("out_unexpected_transfer");
      else begin
        oe = out_q.pop_front();
        chk("out_data", {bus.out_real, bus.out_imag}, {oe.re, oe.im});
        chk("out_ctrl", {bus.out_sop, bus.out_eop, bus.out_exp}, {oe.sop, oe.eop, oe.ex});
        chk("out_src_ready", bus.fft_source_ready, 1);
      end
    end
  end

  task automatic do_start(input int nf, input bit inv);
    bus.num_frames  = nf[7:0];
    bus.inverse_cfg = inv;
    bus.start       = 1'b1;
    exp_inv   = inv;
    frames    = (nf == 0) ? 1 : nf;
    exp_err   = 2'b00;
    done_base = done_cnt;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("start_err_clear", bus.err, 0);
    chk("start_busy", bus.busy, 1);
    chk("start_inverse", bus.fft_inverse, inv);
    @(posedge clk); #1;
  endtask

  task automatic feed(input int n, input int stall_at, input int flip_at);
    logic [31:0] re, im;
    int to;
    for (int k = 0; k < n; k++) begin
      if (k == flip_at) begin
        bus.in_valid    = 1'b0;
        bus.start       = 1'b1;
        bus.inverse_cfg = ~exp_inv;
        bus.num_frames  = 8'($urandom_range(2, 9));
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      if (gaps_en && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      re = $urandom;
      im = $urandom;
      bus.in_real  = re;
      bus.in_imag  = im;
      bus.in_valid = 1'b1;
      sink_q.push_back('{re, im, (k % LEN) == 0, (k % LEN) == LEN - 1, exp_inv});
      if (k == stall_at) begin
        rdy_mode = 2;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("stall_in_ready", bus.in_ready, 0);
        end
        rdy_mode = 0;
      end
      to = 0;
      forever begin
        @(negedge clk);
        if (bus.in_ready) break;
        to++;
        if (to > 200) begin
          fail_now("feed_timeout");
          break;
        end
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic emit(input int n, input int bad_eop_at, input int err_at);
    logic [31:0] re, im;
    logic [5:0] ex;
    logic s, e;
    logic [1:0] er;
    int to;
    for (int k = 0; k < n; k++) begin
      re = $urandom;
      im = $urandom;
      ex = 6'($urandom);
      s  = (k % LEN) == 0;
      e  = ((k % LEN) == LEN - 1) ^ (k == bad_eop_at);
      er = (k == err_at) ? 2'b01 : 2'b00;
      bus.fft_source_real  = re;
      bus.fft_source_imag  = im;
      bus.fft_source_exp   = ex;
      bus.fft_source_sop   = s;
      bus.fft_source_eop   = e;
      bus.fft_source_error = er;
      bus.fft_source_valid = 1'b1;
      out_q.push_back('{re, im, s, e, ex});
      if ((s != ((k % LEN) == 0)) || (e != ((k % LEN) == LEN - 1))) exp_err[1] = 1'b1;
      if (er != 2'b00) exp_err[0] = 1'b1;
      to = 0;
      forever begin
        @(negedge clk);
        if (bus.out_ready) break;
        to++;
        if (to > 200) begin
          fail_now("emit_timeout");
          break;
        end
      end
      @(posedge clk); #1;
    end
    bus.fft_source_valid = 1'b0;
    bus.fft_source_error = 2'b00;
  endtask

  task automatic wait_idle();
    int to = 0;
    while (bus.busy) begin
      @(negedge clk);
      to++;
      if (to > 500) begin
        fail_now("idle_timeout");
        break;
      end
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic job(input int nf, input bit inv, input int stall_at, input int flip_at,
                     input int bad_eop_at, input int err_at);
    do_start(nf, inv);
    feed(frames * LEN, stall_at, flip_at);
    rdy_mode = 1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("drain_in_ready", bus.in_ready, 0);
    chk("drain_sink_valid", bus.fft_sink_valid, 0);
    chk("drain_busy", bus.busy, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rdy_mode = 0;
    emit(frames * LEN, bad_eop_at, err_at);
    wait_idle();
    chk("done_once", done_cnt - done_base, 1);
    chk("job_err", bus.err, exp_err);
    chk("inverse_held", bus.fft_inverse, inv);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.num_frames = 8'd0;
    bus.inverse_cfg = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_real = '0;
    bus.in_imag = '0;
    bus.fft_sink_ready = 1'b1;
    bus.fft_source_valid = 1'b0;
    bus.fft_source_sop = 1'b0;
    bus.fft_source_eop = 1'b0;
    bus.fft_source_error = 2'b00;
    bus.fft_source_real = '0;
    bus.fft_source_imag = '0;
    bus.fft_source_exp = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_inverse", bus.fft_inverse, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_sink_valid", bus.fft_sink_valid, 0);
    chk("rst_sink_error", bus.fft_sink_error, 0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // Two frames, continuous input, toggling downstream ready.
    rdy_mode = 1;
    out_mode = 0;
    job(2, 1'b1, -1, -1, -1, -1);
    rdy_mode = 0;

    // Sink stall mid-frame.
    job(1, 1'b0, 3, -1, -1, -1);

    // Misplaced eop, sticky until next start; then a core error.
    job(1, 1'b1, -1, -1, 5, -1);
    repeat (3) @(negedge clk);
    chk("err_sticky", bus.err, 2'b10);
    @(posedge clk); #1;
    job(2, 1'b0, -1, -1, -1, 10);

    // Ignored start mid-feed, and num_frames=0 meaning one frame.
    job(0, 1'b0, -1, 4, -1, -1);

    // Last input and last output on the same edge.
    rdy_mode = 1;
    out_mode = 1;
    do_start(1, 1'b0);
    fork
      feed(LEN, -1, -1);
      emit(LEN, -1, -1);
    join
    @(negedge clk);
    chk("overlap_idle", bus.busy, 0);
    chk("overlap_done", bus.done, 1);
    repeat (2) @(negedge clk);
    chk("overlap_done_once", done_cnt - done_base, 1);
    @(posedge clk); #1;

    // Reset after three input samples; source path stays live in reset.
    do_start(1, 1'b1);
    feed(3, -1, -1);
    done_base = done_cnt;
    reset_n = 1'b0;
    bus.in_valid = 1'b1;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_sink_valid", bus.fft_sink_valid, 0);
    chk("midrst_inverse", bus.fft_inverse, 0);
    bus.fft_source_real = 32'hCAFE_0001;
    bus.fft_source_imag = 32'hBEEF_0002;
    bus.fft_source_exp = 6'd9;
    bus.fft_source_sop = 1'b1;
    bus.fft_source_eop = 1'b0;
    bus.fft_source_valid = 1'b1;
    out_q.push_back('{32'hCAFE_0001, 32'hBEEF_0002, 1'b1, 1'b0, 6'd9});
    @(posedge clk); #1;
    bus.fft_source_valid = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done_cnt - done_base, 0);
    @(posedge clk); #1;
    rdy_mode = 0;
    out_mode = 0;
    job(1, 1'b0, -1, -1, -1, -1);

    // Randomised jobs with input gaps.
    gaps_en = 1'b1;
    for (int r = 0; r < 4; r++)
      job($urandom_range(1, 3), 1'($urandom_range(0, 1)), -1, -1, -1, -1);
    gaps_en = 1'b0;

    chk("sink_queue_drained", sink_q.size(), 0);
    chk("out_queue_drained", out_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
